// File: rtl/instruction_fetch.sv
// IF stage: keeps the word-addressed fetch PC, issues one-outstanding req/ack reads
// to instruction memory, queues returned words and hands them to decode via valid/ready.
module instruction_fetch #(
    parameter int          PC_WIDTH    = 10,
    parameter int          DATA_WIDTH  = 32,
    parameter int unsigned RESET_PC    = 0,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  branch_sel,
    input  logic [PC_WIDTH-1:0]   jump_address,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] instruc,
    output logic [PC_WIDTH-1:0]   current_PC
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
    localparam logic [CNT_W-1:0]    DEPTH  = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]   addr_q, addr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]   cpc_q, cpc_d;

    logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]   q_pc   [QUEUE_DEPTH];

    logic                  ack_ok;
    logic                  accept;
    logic                  pop;
    logic                  issue;
    logic [PC_WIDTH-1:0]   push_pc;

    assign imem_req   = (state_q != S_IDLE);
    assign imem_addr  = addr_q;
    assign id_valid   = (count_q != '0);
    assign instruc    = instr_q;
    assign current_PC = cpc_q;
    assign push_pc    = addr_q + PC_WIDTH'(1);

    always_comb begin
        ack_ok     = imem_req && imem_ack;
        accept     = ack_ok && (state_q == S_WAIT) && !branch_sel;
        pop        = id_valid && id_ready && !branch_sel;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        instr_d    = instr_q;
        cpc_d      = cpc_q;

        if (branch_sel) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = jump_address;
        end else begin
            if (accept) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
        end

        // Back-to-back issue is judged on post-edge occupancy, so a same-cycle pop frees a slot.
        issue = !branch_sel && (count_d < DEPTH) &&
                ((state_q == S_IDLE) || ((state_q == S_WAIT) && ack_ok));
        if (issue) begin
            addr_d = fetch_pc_d;
        end

        case (state_q)
            S_IDLE:  if (issue) state_d = S_WAIT;
            S_WAIT: begin
                if (ack_ok)          state_d = issue ? S_WAIT : S_IDLE;
                else if (branch_sel) state_d = S_DRAIN;
            end
            S_DRAIN: if (ack_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Head registers follow the entry at the new read pointer; the pushed word bypasses storage.
        if (!branch_sel && (count_d != '0)) begin
            if (accept && (rd_ptr_d == wr_ptr_q)) begin
                instr_d = imem_data;
                cpc_d   = push_pc;
            end else begin
                instr_d = q_data[rd_ptr_d];
                cpc_d   = q_pc[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RST_PC;
            addr_q     <= RST_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            instr_q    <= '0;
            cpc_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            cpc_q      <= cpc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_data[wr_ptr_q] <= imem_data;
            q_pc[wr_ptr_q]   <= push_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: variable-latency memory model plus a scoreboard of
// expected decode-side entries, with one task per scenario.
module tb_instruction_fetch;

    localparam int PW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [DW-1:0] imem_data = '0;
    logic          branch_sel = 1'b0;
    logic [PW-1:0] jump_address = '0;
    logic          id_ready = 1'b0;
    logic          id_valid;
    logic [DW-1:0] instruc;
    logic [PW-1:0] current_PC;

    instruction_fetch #(
        .PC_WIDTH   (PW),
        .DATA_WIDTH (DW),
        .RESET_PC   (0),
        .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .branch_sel  (branch_sel),
        .jump_address(jump_address),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .instruc     (instruc),
        .current_PC  (current_PC)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [PW-1:0] pc;
    } ent_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   mem_lat  = 0;
    int   wait_cnt = 0;
    int   n_acc    = 0;
    ent_t exp_q[$];
    logic [PW-1:0] nxt_pc = '0;
    logic [PW-1:0] prev_addr = '0;
    logic          prev_req = 1'b0;
    logic          prev_ack = 1'b0;
    logic          discard = 1'b0;

    function automatic logic [DW-1:0] word_of(input logic [PW-1:0] a);
        return {16'hC0DE, 6'd0, a};
    endfunction

    // Memory: acks after the request has been held mem_lat cycles.
    always @(negedge clk) begin
        if (!reset_n) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else begin
            if (imem_ack) wait_cnt = 0;
            if (imem_req) begin
                if (wait_cnt >= mem_lat) begin
                    imem_ack  = 1'b1;
                    imem_data = word_of(imem_addr);
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
            end
        end
    end

    // Scoreboard: inputs are stable at negedge+2; predict what the next edge does.
    always @(negedge clk) begin
        logic [PW-1:0] pcn;
        #2;
        if (!reset_n) begin
            exp_q.delete();
            nxt_pc   = '0;
            prev_req = 1'b0;
            prev_ack = 1'b0;
            discard  = 1'b0;
        end else begin
            n_checks++;
            if (id_valid !== (exp_q.size() != 0)) begin
                $display("FAIL sb_valid: id_valid=%b required %b", id_valid, exp_q.size() != 0);
            end else n_pass++;
            if (id_valid === 1'b1 && exp_q.size() != 0) begin
                n_checks++;
                if ({instruc, current_PC} !== exp_q[0]) begin
                    $display("FAIL sb_head: instruc=%h current_PC=%h required %h/%h",
                             instruc, current_PC, exp_q[0].d, exp_q[0].pc);
                end else n_pass++;
            end
            if (prev_req && !prev_ack) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    $display("FAIL sb_hold: req=%b addr=%h required 1/%h", imem_req, imem_addr, prev_addr);
                end else n_pass++;
            end else if (imem_req === 1'b1) begin
                n_checks++;
                if (imem_addr !== nxt_pc) begin
                    $display("FAIL sb_req_addr: addr=%h required %h", imem_addr, nxt_pc);
                end else n_pass++;
            end
            n_checks++;
            if (exp_q.size() + ((imem_req === 1'b1 && !discard) ? 1 : 0) > DEPTH) begin
                $display("FAIL sb_occupancy: queued=%0d req=%b required total<=%0d",
                         exp_q.size(), imem_req, DEPTH);
            end else n_pass++;

            if (id_valid && id_ready && !branch_sel && exp_q.size() != 0) void'(exp_q.pop_front());
            if (imem_req && imem_ack) begin
                if (branch_sel || discard) begin
                    discard = 1'b0;
                end else begin
                    pcn = imem_addr + 1'b1;
                    exp_q.push_back({imem_data, pcn});
                    nxt_pc = pcn;
                    n_acc++;
                end
            end
            if (branch_sel) begin
                exp_q.delete();
                nxt_pc = jump_address;
                if (imem_req && !imem_ack) discard = 1'b1;
            end
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input int lat, input logic rdy);
        step();
        reset_n  = 1'b0;
        mem_lat  = lat;
        id_ready = rdy;
        branch_sel = 1'b0;
        step();
        step();
        n_acc   = 0;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        n_checks++;
        if (imem_req !== 1'b0 || id_valid !== 1'b0 || instruc !== '0 || current_PC !== '0 || imem_addr !== '0) begin
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h addr=%h required all 0",
                     imem_req, id_valid, instruc, current_PC, imem_addr);
        end else n_pass++;
        apply_reset(0, 1'b1);
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL reset_release_req: req=%b required 0", imem_req);
        else n_pass++;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
            $display("FAIL first_req: req=%b addr=%h required 1/000", imem_req, imem_addr);
        end else n_pass++;
    endtask

    task automatic test_stream();
        int guard = 0;
        apply_reset(0, 1'b1);
        while (id_valid !== 1'b1 && guard < 20) begin step(); guard++; end
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (id_valid !== 1'b1 || current_PC !== PW'(k) || instruc !== word_of(PW'(k - 1))) begin
                $display("FAIL stream_%0d: valid=%b pc=%h instr=%h required 1/%h/%h",
                         k, id_valid, current_PC, instruc, PW'(k), word_of(PW'(k - 1)));
            end else n_pass++;
            step();
        end
    endtask

    task automatic test_stall();
        int guard = 0;
        apply_reset(0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (n_acc != 2 || imem_req !== 1'b0 || id_valid !== 1'b1 ||
            instruc !== word_of(10'd0) || current_PC !== 10'd1) begin
            $display("FAIL stall_full: acks=%0d req=%b valid=%b instr=%h pc=%h required 2/0/1/%h/001",
                     n_acc, imem_req, id_valid, instruc, current_PC, word_of(10'd0));
        end else n_pass++;
        id_ready = 1'b1;
        step();
        while (imem_req !== 1'b1 && guard < 10) begin step(); guard++; end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd2) begin
            $display("FAIL stall_resume: req=%b addr=%h required 1/002", imem_req, imem_addr);
        end else n_pass++;
    endtask

    task automatic test_redirect_drain();
        int guard = 0;
        apply_reset(3, 1'b1);
        while (!(imem_req === 1'b1 && imem_addr === 10'd5) && guard < 100) begin step(); guard++; end
        branch_sel   = 1'b1;
        jump_address = 10'h040;
        step();
        branch_sel = 1'b0;
        n_checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'd5) begin
            $display("FAIL drain_hold: valid=%b req=%b addr=%h required 0/1/005", id_valid, imem_req, imem_addr);
        end else n_pass++;
        guard = 0;
        while (!(imem_req === 1'b1 && imem_addr !== 10'd5) && guard < 20) begin step(); guard++; end
        n_checks++;
        if (imem_addr !== 10'h040) $display("FAIL drain_next_addr: addr=%h required 040", imem_addr);
        else n_pass++;
        guard = 0;
        while (id_valid !== 1'b1 && guard < 20) begin step(); guard++; end
        n_checks++;
        if (id_valid !== 1'b1 || current_PC !== 10'h041 || instruc !== word_of(10'h040)) begin
            $display("FAIL drain_first_out: valid=%b pc=%h instr=%h required 1/041/%h",
                     id_valid, current_PC, instruc, word_of(10'h040));
        end else n_pass++;
    endtask

    task automatic test_redirect_on_ack();
        int guard = 0;
        apply_reset(2, 1'b1);
        while (!(imem_req === 1'b1 && imem_ack === 1'b1 && imem_addr === 10'd7) && guard < 100) begin
            step(); guard++;
        end
        branch_sel   = 1'b1;
        jump_address = 10'h100;
        step();
        branch_sel = 1'b0;
        n_checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
            $display("FAIL ack_redirect_idle: valid=%b req=%b required 0/0", id_valid, imem_req);
        end else n_pass++;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h100) begin
            $display("FAIL ack_redirect_addr: req=%b addr=%h required 1/100", imem_req, imem_addr);
        end else n_pass++;
        guard = 0;
        while (id_valid !== 1'b1 && guard < 20) begin step(); guard++; end
        n_checks++;
        if (current_PC !== 10'h101 || instruc !== word_of(10'h100)) begin
            $display("FAIL ack_redirect_out: pc=%h instr=%h required 101/%h", current_PC, instruc, word_of(10'h100));
        end else n_pass++;
    endtask

    task automatic test_wrap();
        int guard = 0;
        apply_reset(1, 1'b1);
        step(); step(); step();
        branch_sel   = 1'b1;
        jump_address = 10'h3FF;
        step();
        branch_sel = 1'b0;
        while (id_valid !== 1'b1 && guard < 20) begin step(); guard++; end
        n_checks++;
        if (id_valid !== 1'b1 || current_PC !== 10'h000 || instruc !== word_of(10'h3FF)) begin
            $display("FAIL wrap_out: valid=%b pc=%h instr=%h required 1/000/%h",
                     id_valid, current_PC, instruc, word_of(10'h3FF));
        end else n_pass++;
        guard = 0;
        while (!(imem_req === 1'b1 && imem_addr !== 10'h3FF) && guard < 20) begin step(); guard++; end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
            $display("FAIL wrap_next_addr: req=%b addr=%h required 1/000", imem_req, imem_addr);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        int guard = 0;
        apply_reset(3, 1'b0);
        while (!(n_acc == 1 && imem_req === 1'b1) && guard < 50) begin step(); guard++; end
        n_checks++;
        if (id_valid !== 1'b1 || imem_req !== 1'b1) begin
            $display("FAIL areset_pre: valid=%b req=%b required 1/1", id_valid, imem_req);
        end else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || id_valid !== 1'b0 || instruc !== '0 || current_PC !== '0 || imem_addr !== '0) begin
            $display("FAIL areset_now: req=%b valid=%b instr=%h pc=%h addr=%h required all 0",
                     imem_req, id_valid, instruc, current_PC, imem_addr);
        end else n_pass++;
        step();
        reset_n  = 1'b1;
        id_ready = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
            $display("FAIL areset_restart: req=%b addr=%h required 1/000", imem_req, imem_addr);
        end else n_pass++;
        guard = 0;
        while (id_valid !== 1'b1 && guard < 20) begin step(); guard++; end
        n_checks++;
        if (current_PC !== 10'd1 || instruc !== word_of(10'd0)) begin
            $display("FAIL areset_first_out: pc=%h instr=%h required 001/%h", current_PC, instruc, word_of(10'd0));
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_redirect_on_ack();
        test_wrap();
        test_async_reset();
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
